// File: rtl/muxn_scan_if.sv
// Channel/select bundle for the registered N-to-1 scanning multiplexer.
// The master side supplies the channels, select and control; the slave
// side (the mux itself) returns the sampled data, its channel tag and
// the wrap pulse.
interface muxn_scan_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int S = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] x;
  logic [S-1:0]   ss;
  logic           mode;
  logic           en;
  logic [W-1:0]   y;
  logic [S-1:0]   sel_out;
  logic           wrap;

  modport master (
    output x, ss, mode, en,
    input  y, sel_out, wrap
  );

  modport slave (
    input  x, ss, mode, en,
    output y, sel_out, wrap
  );
endinterface

// File: rtl/muxn_scan.sv
// Registered N-to-1 multiplexer with manual and round-robin scan modes.
// In scan mode each channel is held for DWELL enabled cycles; sel_out
// always names the channel that y was sampled from on the same cycle,
// and wrap pulses for one cycle when the scan steps from N-1 back to 0.
`default_nettype none

module muxn_scan #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  wire logic   CLK,
  input  wire logic   N_RESET,
  muxn_scan_if.slave  bus
);

  localparam int S  = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [S-1:0]  LAST_SEL = S'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [S-1:0]  r_sel;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_y;
  logic          r_wrap;

  logic [S-1:0]  w_ssSel;
  logic [S-1:0]  w_selNext;
  logic [CW-1:0] w_cntNext;
  logic          w_wrapNext;
  logic [W-1:0]  w_yNext;
  logic [W-1:0]  w_chan [0:N-1];

  // Unpack the flat channel bus so the data mux can index it by channel.
  for (genvar k = 0; k < N; k++) begin : g_chan
    assign w_chan[k] = bus.x[k*W +: W];
  end

  // A manual select beyond the last channel can only occur when N is not
  // a power of two; such values park on the last channel.
  if ((1 << S) == N) begin : g_pow2
    assign w_ssSel = bus.ss;
  end else begin : g_clamp
    assign w_ssSel = (bus.ss > LAST_SEL) ? LAST_SEL : bus.ss;
  end

  // Next channel, dwell count and wrap flag for an enabled edge.
  always_comb begin
    w_selNext  = r_sel;
    w_cntNext  = r_cnt;
    w_wrapNext = 1'b0;
    if (!bus.mode) begin
      w_selNext = w_ssSel;
      w_cntNext = '0;
    end else if (r_cnt == LAST_CNT) begin
      w_cntNext = '0;
      if (r_sel == LAST_SEL) begin
        w_selNext  = '0;
        w_wrapNext = 1'b1;
      end else begin
        w_selNext = r_sel + 1'b1;
      end
    end else begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  // Data is taken from the channel being selected this edge, so y and
  // sel_out always describe the same channel.
  assign w_yNext = w_chan[w_selNext];

  // State registers; a disabled edge freezes everything except wrap.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_sel  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_wrap <= 1'b0;
    end else if (bus.en) begin
      r_sel  <= w_selNext;
      r_cnt  <= w_cntNext;
      r_y    <= w_yNext;
      r_wrap <= w_wrapNext;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.y       = r_y;
  assign bus.sel_out = r_sel;
  assign bus.wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan. Two instances: A (N=8, W=1, DWELL=2)
// takes the directed scenarios plus random traffic, B (N=5, W=2, DWELL=3)
// exercises select clamping and wider channels with random traffic.
// Both are compared every cycle against a positional scan model.
`timescale 1ns/1ps

module tb_muxn_scan;

  logic CLK;
  logic N_RESET;

  muxn_scan_if #(.N(8), .W(1)) busA ();
  muxn_scan_if #(.N(5), .W(2)) busB ();

  muxn_scan #(.N(8), .W(1), .DWELL(2)) dutA (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .bus     (busA)
  );

  muxn_scan #(.N(5), .W(2), .DWELL(3)) dutB (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .bus     (busB)
  );

  int checks;
  int passes;
  bit checkEn;

  // Model state: in scan mode the channel is derived from the number of
  // enabled scan edges since scanning began and the channel it began on.
  typedef struct {
    int sel;
    int y;
    int wrap;
    int base;
    int pos;
  } mstate_t;

  localparam mstate_t RST_STATE = '{sel: 0, y: 0, wrap: 0, base: 0, pos: 0};

  mstate_t mA;
  mstate_t mB;

  function automatic mstate_t modelStep(mstate_t s, int n, int w, int dw,
                                        logic [31:0] xv, int ssv,
                                        logic modev, logic env);
    mstate_t r;
    r = s;
    r.wrap = 0;
    if (env !== 1'b1) return r;
    if (modev == 1'b0) begin
      r.sel  = (ssv >= n) ? n - 1 : ssv;
      r.base = r.sel;
      r.pos  = 0;
    end else begin
      r.pos = r.pos + 1;
      r.sel = (r.base + r.pos / dw) % n;
      if ((r.pos % dw) == 0 && r.sel == 0) r.wrap = 1;
    end
    r.y = int'((xv >> (r.sel * w)) & ((32'd1 << w) - 32'd1));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance the model on every clock edge, or clear it on reset.
  always @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      mA = RST_STATE;
      mB = RST_STATE;
    end else begin
      mA = modelStep(mA, 8, 1, 2, 32'(busA.x), int'(busA.ss), busA.mode, busA.en);
      mB = modelStep(mB, 5, 2, 3, 32'(busB.x), int'(busB.ss), busB.mode, busB.en);
    end
  end

  // Compare both instances against the model just after every edge.
  always @(posedge CLK) begin
    #1;
    if (checkEn && N_RESET) begin
      checkOutput("A.y",    32'(busA.y),       32'(mA.y));
      checkOutput("A.sel",  32'(busA.sel_out), 32'(mA.sel));
      checkOutput("A.wrap", 32'(busA.wrap),    32'(mA.wrap));
      checkOutput("B.y",    32'(busB.y),       32'(mB.y));
      checkOutput("B.sel",  32'(busB.sel_out), 32'(mB.sel));
      checkOutput("B.wrap", 32'(busB.wrap),    32'(mB.wrap));
    end
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic m, input logic e, input int s,
                               input logic [7:0] xv);
    @(negedge CLK);
    busA.mode = m;
    busA.en   = e;
    busA.ss   = 3'(s);
    busA.x    = xv;
  endtask

  task automatic waitEdge();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkZeroA(input string tag);
    checkOutput({tag, ".y"},    32'(busA.y),       32'd0);
    checkOutput({tag, ".sel"},  32'(busA.sel_out), 32'd0);
    checkOutput({tag, ".wrap"}, 32'(busA.wrap),    32'd0);
  endtask

  // Assert reset between edges, check the immediate effect, then release
  // with both instances disabled so the release cycle does not move them.
  task automatic pulseReset();
    @(negedge CLK);
    #2;
    busA.en = 1'b0;
    busB.en = 1'b0;
    N_RESET = 1'b0;
    #1;
    checkZeroA("rstA");
    @(negedge CLK);
    N_RESET = 1'b1;
  endtask

  initial begin
    int k;
    bit found;
    logic mA_mode;
    logic mB_mode;

    checks  = 0;
    passes  = 0;
    checkEn = 1'b0;
    N_RESET = 1'b1;
    busA.x = 8'h55; busA.ss = '0; busA.mode = 1'b0; busA.en = 1'b0;
    busB.x = '0;    busB.ss = '0; busB.mode = 1'b0; busB.en = 1'b0;

    // Reset asserted between edges takes effect at once.
    #3;
    N_RESET = 1'b0;
    #1;
    checkZeroA("init");
    checkOutput("initB.sel", 32'(busB.sel_out), 32'd0);
    checkEn = 1'b1;
    @(negedge CLK);
    N_RESET = 1'b1;

    // Manual select of channel 3 (bit 3 of 0x55 is 0).
    applyStimulus(1'b0, 1'b1, 3, 8'h55);
    waitEdge();
    checkOutput("t1.sel", 32'(busA.sel_out), 32'd3);
    checkOutput("t1.y",   32'(busA.y),       32'd0);

    // Manual sweep over every channel.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, i, 8'h55);
      waitEdge();
      checkOutput("t2.sel", 32'(busA.sel_out), 32'(i));
      checkOutput("t2.y",   32'(busA.y),       (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Scan from reset: 0,1,1,2,2,...,7,7,0 with wrap on the last step.
    pulseReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 0, 8'h55);
      waitEdge();
      checkOutput("t3.sel",  32'(busA.sel_out), 32'(((i + 1) / 2) % 8));
      checkOutput("t3.wrap", 32'(busA.wrap),    (i == 15) ? 32'd1 : 32'd0);
    end

    // Enable gating on the second dwell cycle of channel 4.
    pulseReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 0, 8'h55);
      waitEdge();
    end
    checkOutput("t4.pre", 32'(busA.sel_out), 32'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 8'h55);
      waitEdge();
      checkOutput("t4.sel",  32'(busA.sel_out), 32'd4);
      checkOutput("t4.y",    32'(busA.y),       32'd1);
      checkOutput("t4.wrap", 32'(busA.wrap),    32'd0);
    end
    applyStimulus(1'b1, 1'b1, 0, 8'h55);
    waitEdge();
    checkOutput("t4.resume", 32'(busA.sel_out), 32'd5);

    // Scan until channel 6, then switch to manual channel 2.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 0, 8'h55);
      waitEdge();
      if (busA.sel_out == 3'd6) found = 1'b1;
    end
    checkOutput("t5.reach6", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 2, 8'h55);
    waitEdge();
    checkOutput("t5.sel", 32'(busA.sel_out), 32'd2);
    checkOutput("t5.y",   32'(busA.y),       32'd1);
    applyStimulus(1'b1, 1'b1, 0, 8'h55);
    waitEdge();
    checkOutput("t5.hold", 32'(busA.sel_out), 32'd2);
    applyStimulus(1'b1, 1'b1, 0, 8'h55);
    waitEdge();
    checkOutput("t5.step", 32'(busA.sel_out), 32'd3);

    // Reset mid-scan at channel 5; scan restarts from channel 0.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 0, 8'h55);
      waitEdge();
      if (busA.sel_out == 3'd5) found = 1'b1;
    end
    checkOutput("t6.reach5", 32'(found), 32'd1);
    pulseReset();
    applyStimulus(1'b1, 1'b1, 0, 8'h55);
    waitEdge();
    checkOutput("t6.sel0", 32'(busA.sel_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 0, 8'h55);
    waitEdge();
    checkOutput("t6.sel1", 32'(busA.sel_out), 32'd1);

    // Data change on a steady manual channel.
    applyStimulus(1'b0, 1'b1, 1, 8'h55);
    waitEdge();
    checkOutput("t6.yOld", 32'(busA.y), 32'd0);
    applyStimulus(1'b0, 1'b1, 1, 8'hFF);
    waitEdge();
    checkOutput("t6.yNew", 32'(busA.y), 32'd1);

    // Instance B: out-of-range select parks on channel 4.
    @(negedge CLK);
    busB.mode = 1'b0; busB.en = 1'b1; busB.ss = 3'd6; busB.x = 10'h200;
    waitEdge();
    checkOutput("b.clampSel", 32'(busB.sel_out), 32'd4);
    checkOutput("b.clampY",   32'(busB.y),       32'd2);

    // Random traffic on both instances with occasional async resets.
    mA_mode = 1'b1;
    mB_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) mA_mode = ~mA_mode;
      if ($urandom_range(0, 7) == 0) mB_mode = ~mB_mode;
      busA.mode = mA_mode;
      busA.en   = ($urandom_range(0, 4) != 0);
      busA.ss   = 3'($urandom_range(0, 7));
      busA.x    = 8'($urandom());
      busB.mode = mB_mode;
      busB.en   = ($urandom_range(0, 4) != 0);
      busB.ss   = 3'($urandom_range(0, 7));
      busB.x    = 10'($urandom());
      k = int'($urandom_range(0, 79));
      if (k == 0) begin
        #2;
        N_RESET = 1'b0;
        #1;
        checkZeroA("rndRst");
        checkOutput("rndRstB.sel", 32'(busB.sel_out), 32'd0);
        @(negedge CLK);
        busA.en = 1'b0;
        busB.en = 1'b0;
        N_RESET = 1'b1;
      end
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
